// File: rtl/snn_pkg.sv
// snn_pkg: shared state encoding and image sizing for the SNN load/infer sequencer
package snn_pkg;
  localparam int IMG_BITS_DEF = 784;
  localparam int IMG_BYTES = IMG_BITS_DEF / 8;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  localparam int BYTE_CNT_W = cnt_w(IMG_BYTES);
  typedef enum logic [2:0] {IDLE, LOAD, UNPACK, START, INFER, TX, TX_WAIT} state_t;
endpackage

// File: rtl/snn_byte_unpacker.sv
// snn_byte_unpacker: 1-deep byte hold reg feeding an 8-cycle bit-serial shifter
//   push      in  accept din (caller guarantees ready)
//   din       in  byte, bit0 emitted first
//   pix       out current bit
//   valid     out pix is being emitted this cycle
//   last      out bit 7 of the current byte
//   hold_full out a byte waits behind the one being shifted
//   ready     out a push this cycle will not be lost
module snn_byte_unpacker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       pix,
  output logic       valid,
  output logic       last,
  output logic       hold_full,
  output logic       ready
);
  logic [7:0] hold, sh;
  logic [2:0] cnt;
  logic take;
  assign pix = sh[0];
  assign last = valid && cnt == 3'd7;
  // shifter can take a new byte at the next edge: idle, or emitting its last bit
  assign take = !valid || last;
  assign ready = !hold_full || take;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hold <= '0;
      sh <= '0;
      cnt <= '0;
      valid <= 1'b0;
      hold_full <= 1'b0;
    end else begin
      cnt <= take ? 3'd0 : cnt + 3'd1;
      if (push) hold <= din;
      if (take) begin
        valid <= hold_full || push;
        sh <= hold_full ? hold : din;
        hold_full <= hold_full && push;
      end else begin
        sh <= sh >> 1;
        hold_full <= hold_full || push;
      end
    end
endmodule

// File: rtl/snn_seq_ctrl.sv
// snn_seq_ctrl: loads a 98-byte binary image from UART into the 1-bit image RAM, runs inference, reports the digit
//   clk, rst_n           clock, async active-low reset
//   rx_rdy, rx_data      received byte strobe / byte (bit0 = lowest pixel address)
//   ram_we/addr/wdata    image RAM write port
//   inf_start            1-cycle inference start pulse
//   inf_done, inf_digit  inference result strobe / digit
//   tx_start, tx_data    1-cycle UART send pulse / {4'h0, digit}
//   tx_rdy               UART TX idle
//   led                  {4'h0, last digit}
//   busy                 not IDLE
//   ovr                  sticky byte-dropped flag, cleared by the first byte of the next image
// Option SNN_TIMEOUT_EN: abandon a partial image after TIMEOUT_CYC idle cycles in LOAD.
module snn_seq_ctrl
  import snn_pkg::*;
#(
  parameter int IMG_BITS = IMG_BITS_DEF,
  parameter int ADDR_W = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wdata,
  output logic              inf_start,
  input  logic              inf_done,
  input  logic [3:0]        inf_digit,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_rdy,
  output logic [7:0]        led,
  output logic              busy,
  output logic              ovr
);
  localparam int NB = IMG_BITS / 8;
  localparam int CW = cnt_w(NB);
  state_t state;
  logic [CW-1:0] byte_cnt;
  logic skip, push, rx_ok, last, hold_full, ready, full_img;
`ifdef SNN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_cnt;
`endif
  // byte_cnt counts accepted bytes, so nothing past the last image byte is taken
  assign full_img = byte_cnt == CW'(NB);
  assign rx_ok = state == IDLE || ((state == LOAD || state == UNPACK) && ready && !full_img);
  assign push = rx_rdy && rx_ok;
  assign busy = state != IDLE;
  snn_byte_unpacker u_unp (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din(rx_data),
    .pix(ram_wdata),
    .valid(ram_we),
    .last(last),
    .hold_full(hold_full),
    .ready(ready)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      byte_cnt <= '0;
      ram_addr <= '0;
      ovr <= 1'b0;
      inf_start <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= '0;
      led <= '0;
      skip <= 1'b0;
`ifdef SNN_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else begin
      if (rx_rdy && !rx_ok) ovr <= 1'b1;
      if (push) byte_cnt <= byte_cnt + 1'b1;
      if (ram_we) ram_addr <= ram_addr + 1'b1;
      inf_start <= 1'b0;
      tx_start <= 1'b0;
`ifdef SNN_TIMEOUT_EN
      to_cnt <= (state == LOAD && !push) ? to_cnt + 1'b1 : '0;
`endif
      case (state)
        IDLE: if (rx_rdy) begin
          ovr <= 1'b0;
          ram_addr <= '0;
          byte_cnt <= CW'(1);
          state <= UNPACK;
        end
`ifdef SNN_TIMEOUT_EN
        LOAD: if (push) state <= UNPACK;
        else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          state <= IDLE;
          byte_cnt <= '0;
          ram_addr <= '0;
          ovr <= 1'b1;
        end
`else
        LOAD: if (push) state <= UNPACK;
`endif
        // a byte already held or arriving now continues unpacking without a bubble
        UNPACK: if (last && !hold_full && !push) begin
          state <= full_img ? START : LOAD;
          inf_start <= full_img;
        end
        START: state <= INFER;
        INFER: if (inf_done) begin
          led <= {4'h0, inf_digit};
          tx_data <= {4'h0, inf_digit};
          state <= TX;
        end
        TX: if (tx_rdy) begin
          tx_start <= 1'b1;
          skip <= 1'b1;
          state <= TX_WAIT;
        end
        // tx_rdy is stale while tx_start is high and on the following cycle
        TX_WAIT: begin
          if (!tx_start) skip <= 1'b0;
          if (!tx_start && !skip && tx_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_snn_seq_ctrl.sv
// tb_snn_seq_ctrl: scoreboard bench for the SNN load/infer sequencer
`timescale 1ns/1ps
module tb_snn_seq_ctrl;
  import snn_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, rx_rdy = 1'b0, inf_done = 1'b0, tx_rdy = 1'b1;
  logic [7:0] rx_data = '0;
  logic [3:0] inf_digit = '0;
  logic ram_we, ram_wdata, inf_start, tx_start, busy, ovr;
  logic [9:0] ram_addr;
  logic [7:0] tx_data, led;
  int total = 0, bad = 0, inf_cnt = 0, tx_cnt = 0, exp_addr = 0, exp_inf = 0, e;
  int wq[$];
  logic [7:0] txq[$];
  always #5 clk = ~clk;
  snn_seq_ctrl #(.TIMEOUT_CYC(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .inf_start(inf_start),
    .inf_done(inf_done),
    .inf_digit(inf_digit),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_rdy(tx_rdy),
    .led(led),
    .busy(busy),
    .ovr(ovr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_we) begin
      chk("wr_expected", wq.size() != 0, 1);
      if (wq.size() != 0) begin
        e = wq.pop_front();
        chk("wr_addr", ram_addr, e >> 1);
        chk("wr_bit", ram_wdata, e & 1);
      end
    end
    if (inf_start) inf_cnt++;
    if (tx_start) begin
      tx_cnt++;
      chk("tx_expected", txq.size() != 0, 1);
      if (txq.size() != 0) chk("tx_data", tx_data, txq.pop_front());
    end
  end
  task automatic send(input logic [7:0] b, input int gap, input bit acc);
    @(negedge clk);
    rx_data = b;
    rx_rdy = 1'b1;
    if (acc) begin
      for (int k = 0; k < 8; k++) wq.push_back((exp_addr + k) * 2 + int'(b[k]));
      exp_addr += 8;
    end
    @(negedge clk);
    rx_rdy = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask
  task automatic load_image(input int mode, input int seed);
    exp_addr = 0;
    for (int i = 0; i < IMG_BYTES; i++)
      send(mode == 0 ? 8'hA5 : 8'(i * 37 + seed), mode == 0 ? 10 : (i % 2 == 0 ? 2 : 16), 1'b1);
  endtask
  task automatic wait_inf(input int n);
    int c = 0;
    while (inf_cnt < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("inf_start_seen", inf_cnt, n);
    chk("wr_drained", wq.size(), 0);
  endtask
  task automatic infer_tx(input logic [3:0] d, input int low);
    int c;
    repeat (3) @(negedge clk);
    chk("busy_infer", busy, 1);
    if (low > 0) tx_rdy = 1'b0;
    inf_done = 1'b1;
    inf_digit = d;
    txq.push_back({4'h0, d});
    @(negedge clk);
    inf_done = 1'b0;
    chk("led", led, {4'h0, d});
    c = tx_cnt;
    repeat (low) @(negedge clk);
    chk("tx_withheld", tx_cnt, c);
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("tx_start_now", tx_start, 1);
    tx_rdy = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_tx_wait", busy, 1);
    chk("tx_once", tx_cnt, c + 1);
    tx_rdy = 1'b1;
    @(negedge clk);
    chk("busy_done", busy, 0);
    chk("led_hold", led, {4'h0, d});
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_inf_start", inf_start, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_led", led, 0);
    rst_n = 1'b1;
    load_image(0, 0);
    wait_inf(++exp_inf);
    chk("ovr_img1", ovr, 0);
    send(8'h3C, 2, 1'b0);
    chk("ovr_infer_drop", ovr, 1);
    infer_tx(4'd7, 50);
    load_image(1, 5);
    wait_inf(++exp_inf);
    chk("ovr_pairs", ovr, 0);
    infer_tx(4'd3, 0);
    exp_addr = 0;
    send(8'h11, 2, 1'b1);
    send(8'h22, 2, 1'b1);
    send(8'h33, 2, 1'b0);
    chk("ovr_third", ovr, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 37; i++) send(8'(i * 11 + 3), 10, 1'b1);
    repeat (12) @(negedge clk);
    chk("part_drained", wq.size(), 0);
    chk("part_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovr", ovr, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", ram_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load_image(1, 9);
    wait_inf(++exp_inf);
    infer_tx(4'd12, 0);
`ifdef SNN_TIMEOUT_EN
    exp_addr = 0;
    for (int i = 0; i < 10; i++) send(8'(i + 1), 10, 1'b1);
    repeat (130) @(negedge clk);
    chk("to_busy", busy, 0);
    chk("to_ovr", ovr, 1);
    chk("to_drained", wq.size(), 0);
    load_image(0, 0);
    wait_inf(++exp_inf);
    infer_tx(4'd1, 0);
`endif
    repeat (5) @(negedge clk);
    chk("inf_total", inf_cnt, exp_inf);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
